// File: rtl/usb_utmi_pkg.sv
// Shared types and helpers for the UTMI transmit path.
package usb_utmi_pkg;

    localparam int UTMI_DW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TX   = 2'd1,
        GAP  = 2'd2
    } utmi_tx_state_e;

    // Increment a requester index with wrap at n.
    function automatic int rr_wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/usb_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, one-hot plus index.
module usb_rr_arbiter
    import usb_utmi_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);

    logic [PW-1:0] k;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        k   = ptr;
        for (int i = 0; i < N; i++) begin
            if (!any && req[k]) begin
                any    = 1'b1;
                idx    = k;
                gnt[k] = 1'b1;
            end
            k = PW'(rr_wrap_inc(int'(k), N));
        end
    end

endmodule

// File: rtl/utmi_tx_arbiter.sv
// Packet-granular round-robin sharing of the UTMI TX byte interface, with
// inter-packet gap, TXReady timeout, underrun abort and RXActive hold-off.
module utmi_tx_arbiter
    import usb_utmi_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int IPG_CYCLES = 8,
    parameter int TXRDY_TMO  = 64
) (
    input  logic                              clk_60mhz,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ-1:0][UTMI_DW-1:0]   req_data,
    input  logic [NUM_REQ-1:0]                req_last,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic [NUM_REQ-1:0]                grant,
    input  logic                              rx_active,
    output logic                              TXValid,
    output logic [UTMI_DW-1:0]                DataIn,
    input  logic                              TXReady,
    output logic                              tx_done,
    output logic                              tx_abort,
    output logic                              busy
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    utmi_tx_state_e       state_q, state_d;
    logic [UTMI_DW-1:0]   hold_q;
    logic                 last_q;
    logic [PW-1:0]        owner_q, owner_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic                 txv_q, txv_d;
    logic [9:0]           tmo_q, tmo_d;
    logic [7:0]           gap_q, gap_d;
    logic                 load;
    logic [PW-1:0]        load_sel;

    logic [NUM_REQ-1:0]   arb_gnt;
    logic [PW-1:0]        arb_idx;
    logic                 arb_any;

    // ptr_q holds the index where the next search begins (one past the last winner).
    usb_rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        txv_d     = txv_q;
        tmo_d     = tmo_q;
        gap_d     = gap_q;
        load      = 1'b0;
        load_sel  = owner_q;
        req_ready = '0;
        tx_done   = 1'b0;
        tx_abort  = 1'b0;
        unique case (state_q)
            IDLE: begin
                tmo_d = '0;
                gap_d = '0;
                // rst gating keeps req_ready quiet while reset is held.
                if (arb_any && !rx_active && rst) begin
                    grant_d   = arb_gnt;
                    owner_d   = arb_idx;
                    ptr_d     = PW'(rr_wrap_inc(int'(arb_idx), NUM_REQ));
                    req_ready = arb_gnt;
                    load      = 1'b1;
                    load_sel  = arb_idx;
                    txv_d     = 1'b1;
                    state_d   = TX;
                end
            end
            TX: begin
                if (TXReady) begin
                    tmo_d = '0;
                    if (last_q) begin
                        tx_done = 1'b1;
                        state_d = GAP;
                    end else if (req_valid[owner_q]) begin
                        req_ready[owner_q] = 1'b1;
                        load               = 1'b1;
                    end else begin
                        tx_abort = 1'b1;
                        state_d  = GAP;
                    end
                end else if (tmo_q >= 10'(TXRDY_TMO - 1)) begin
                    tx_abort = 1'b1;
                    state_d  = GAP;
                end else begin
                    tmo_d = tmo_q + 10'd1;
                end
                if (state_d == GAP) begin
                    grant_d = '0;
                    txv_d   = 1'b0;
                    gap_d   = '0;
                    tmo_d   = '0;
                end
            end
            GAP: begin
                if (gap_q >= 8'(IPG_CYCLES - 1)) begin
                    gap_d   = '0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_60mhz or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            last_q  <= 1'b0;
            owner_q <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            txv_q   <= 1'b0;
            tmo_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            txv_q   <= txv_d;
            tmo_q   <= tmo_d;
            gap_q   <= gap_d;
            if (load) begin
                hold_q <= req_data[load_sel];
                last_q <= req_last[load_sel];
            end
        end
    end

    assign grant   = grant_q;
    assign TXValid = txv_q;
    assign DataIn  = txv_q ? hold_q : '0;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_utmi_tx_arbiter.sv
// Directed scenarios plus randomized traffic checked by a packet-level scoreboard.
module tb_utmi_tx_arbiter;
    import usb_utmi_pkg::*;

    localparam int N   = 2;
    localparam int IPG = 8;
    localparam int TMO = 64;

    logic                      clk_60mhz = 1'b0;
    logic                      rst = 1'b0;
    logic [N-1:0]              req_valid;
    logic [N-1:0][7:0]         req_data;
    logic [N-1:0]              req_last;
    logic [N-1:0]              req_ready;
    logic [N-1:0]              grant;
    logic                      rx_active;
    logic                      TXValid;
    logic [7:0]                DataIn;
    logic                      TXReady;
    logic                      tx_done;
    logic                      tx_abort;
    logic                      busy;

    always #5 clk_60mhz = ~clk_60mhz;

    utmi_tx_arbiter #(.NUM_REQ(N), .IPG_CYCLES(IPG), .TXRDY_TMO(TMO)) dut (
        .clk_60mhz (clk_60mhz),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .grant     (grant),
        .rx_active (rx_active),
        .TXValid   (TXValid),
        .DataIn    (DataIn),
        .TXReady   (TXReady),
        .tx_done   (tx_done),
        .tx_abort  (tx_abort),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Requester side: each queue entry is {last, byte}.
    logic [8:0]   pq  [N][$];
    logic [7:0]   exq [N][$];
    logic [N-1:0] en;

    int           done_cnt, abort_cnt, cyc, end_cyc, last_w;
    bit           sb_on;
    logic [N-1:0] prev_grant, prev_valid;
    logic         prev_rx, prev_txv;

    function automatic int oh2idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = en[i] && (pq[i].size() > 0);
            req_data[i]  = (pq[i].size() > 0) ? pq[i][0][7:0] : 8'h00;
            req_last[i]  = (pq[i].size() > 0) ? pq[i][0][8] : 1'b0;
        end
        #1;
    endtask

    task automatic model_reset();
        prev_grant = '0;
        prev_valid = '0;
        prev_rx    = 1'b0;
        prev_txv   = 1'b0;
        last_w     = N - 1;
        end_cyc    = -1000;
    endtask

    // Samples one cycle's outputs; scoreboard checks only when sb_on.
    task automatic monitor();
        int           o;
        int           w;
        logic [N-1:0] sh;
        logic [N-1:0] eg;
        if (TXValid && TXReady && sb_on) begin
            o = oh2idx(grant);
            chk("sb_pending", (o >= 0) && (exq[o >= 0 ? o : 0].size() > 0), 1);
            if (o >= 0 && exq[o].size() > 0)
                chk("sb_byte", DataIn, exq[o].pop_front());
        end
        done_cnt  += int'(tx_done);
        abort_cnt += int'(tx_abort);
        if (prev_grant == '0 && grant != '0) begin
            w = -1;
            for (int k = 1; k <= N; k++) begin
                sh = prev_valid >> ((last_w + k) % N);
                if (w < 0 && sh[0]) w = (last_w + k) % N;
            end
            eg = '0;
            if (w >= 0) eg = {{(N-1){1'b0}}, 1'b1} << w;
            if (sb_on) begin
                chk("rr_winner", grant, eg);
                chk("rx_gate", prev_rx, 0);
                chk("ipg_min", (cyc - end_cyc) >= IPG + 1, 1);
            end
            last_w = oh2idx(grant);
        end
        if (prev_txv && !TXValid) end_cyc = cyc;
        prev_grant = grant;
        prev_valid = req_valid;
        prev_rx    = rx_active;
        prev_txv   = TXValid;
    endtask

    task automatic step();
        logic [N-1:0] taken;
        monitor();
        taken = req_ready;
        @(posedge clk_60mhz);
        #1;
        cyc++;
        for (int i = 0; i < N; i++)
            if (taken[i] && pq[i].size() > 0) void'(pq[i].pop_front());
        drive();
    endtask

    task automatic flush();
        for (int i = 0; i < N; i++) begin
            pq[i].delete();
            exq[i].delete();
        end
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        flush();
        en        = '1;
        TXReady   = 1'b1;
        rx_active = 1'b0;
        drive();
        repeat (2) @(posedge clk_60mhz);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
    endtask

    task automatic push_byte(input int i, input logic [7:0] b, input logic last, input bit sb);
        pq[i].push_back({last, b});
        if (sb) exq[i].push_back(b);
    endtask

    task automatic push_pkt(input int i, input int len, input bit sb);
        for (int j = 0; j < len; j++)
            push_byte(i, 8'($urandom), j == len - 1, sb);
    endtask

    task automatic wait_grant(output logic [N-1:0] g);
        int n = 0;
        while (grant == '0 && n < 300) begin
            step();
            n++;
        end
        g = grant;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy || grant != '0) && n < 2000) begin
            step();
            n++;
        end
        chk(tag, n < 2000, 1);
    endtask

    initial begin
        logic [N-1:0] g;
        int           n, m, pk, d0, a0;
        bit           bad;
        int           run;
        logic [7:0]   b4 [4];

        req_valid = '0; req_data = '0; req_last = '0;
        TXReady = 1'b1; rx_active = 1'b0; en = '1;
        cyc = 0; done_cnt = 0; abort_cnt = 0; sb_on = 1'b0;
        model_reset();

        // Reset state and a 3-byte packet at full rate.
        do_reset();
        chk("rst_txvalid", TXValid, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_datain", DataIn, 0);
        push_byte(0, 8'hA5, 1'b0, 1'b0);
        push_byte(0, 8'h5A, 1'b0, 1'b0);
        push_byte(0, 8'hC3, 1'b1, 1'b0);
        drive();
        chk("t1_ready_idle", req_ready, 2'b01);
        d0 = done_cnt;
        step();
        chk("t1_txv", TXValid, 1);
        chk("t1_b0", DataIn, 8'hA5);
        chk("t1_grant", grant, 2'b01);
        step();
        chk("t1_b1", DataIn, 8'h5A);
        chk("t1_nodone", tx_done, 0);
        step();
        chk("t1_b2", DataIn, 8'hC3);
        chk("t1_done", tx_done, 1);
        step();
        chk("t1_txv_drop", TXValid, 0);
        chk("t1_grant_drop", grant, 0);
        chk("t1_busy_gap", busy, 1);
        n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        chk("t1_gap_len", n, IPG);
        chk("t1_done_cnt", done_cnt - d0, 1);

        // Two requesters contending: 0, then 1, then 0 again.
        do_reset();
        push_pkt(0, 2, 1'b0);
        push_pkt(0, 1, 1'b0);
        push_pkt(1, 2, 1'b0);
        drive();
        wait_grant(g);
        chk("t2_first", g, 2'b01);
        n = 0;
        while (grant != '0 && n < 100) begin
            step();
            n++;
        end
        m = 0;
        while (grant == '0 && m < 100) begin
            step();
            m++;
        end
        chk("t2_gap_cycles", m, IPG + 1);
        chk("t2_second", grant, 2'b10);
        n = 0;
        while (grant != '0 && n < 100) begin
            step();
            n++;
        end
        wait_grant(g);
        chk("t2_third", g, 2'b01);
        wait_idle("t2_idle");

        // TXReady stuck low: abort on the TMO-th cycle of TXValid.
        do_reset();
        TXReady = 1'b0;
        push_pkt(0, 3, 1'b0);
        drive();
        d0 = done_cnt;
        wait_grant(g);
        chk("t3_grant", g, 2'b01);
        n = 1;
        while (!tx_abort && n < 200) begin
            step();
            n++;
        end
        chk("t3_tmo_cycle", n, TMO);
        chk("t3_txv_at_abort", TXValid, 1);
        step();
        chk("t3_txv_drop", TXValid, 0);
        chk("t3_grant_drop", grant, 0);
        chk("t3_busy_gap", busy, 1);
        chk("t3_nodone", done_cnt - d0, 0);
        flush();
        TXReady = 1'b1;
        drive();
        wait_idle("t3_idle");

        // Underrun: requester 1 withdraws after its first byte.
        for (int j = 0; j < 4; j++) begin
            b4[j] = 8'($urandom);
            push_byte(1, b4[j], j == 3, 1'b0);
        end
        drive();
        d0 = done_cnt;
        wait_grant(g);
        chk("t4_grant", g, 2'b10);
        chk("t4_b0", DataIn, b4[0]);
        en[1] = 1'b0;
        drive();
        chk("t4_abort", tx_abort, 1);
        chk("t4_nodone", tx_done, 0);
        step();
        chk("t4_grant_drop", grant, 0);
        chk("t4_txv_drop", TXValid, 0);
        chk("t4_nodone_cnt", done_cnt - d0, 0);
        flush();
        en = '1;
        drive();
        wait_idle("t4_idle");

        // RXActive holds off a new grant.
        rx_active = 1'b1;
        push_pkt(0, 2, 1'b0);
        drive();
        bad = 1'b0;
        repeat (6) begin
            if (grant != '0 || req_ready != '0 || TXValid) bad = 1'b1;
            step();
        end
        chk("t5_blocked", bad, 0);
        rx_active = 1'b0;
        drive();
        chk("t5_ready", req_ready, 2'b01);
        step();
        chk("t5_grant", grant, 2'b01);
        wait_idle("t5_idle");

        // Reset mid-packet, then fresh arbitration starts at requester 0.
        push_pkt(0, 6, 1'b0);
        drive();
        wait_grant(g);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("t6_txv", TXValid, 0);
        chk("t6_grant", grant, 0);
        chk("t6_ready", req_ready, 0);
        chk("t6_busy", busy, 0);
        flush();
        push_pkt(1, 1, 1'b0);
        push_pkt(0, 1, 1'b0);
        drive();
        chk("t6_ready_in_rst", req_ready, 0);
        @(posedge clk_60mhz);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        wait_grant(g);
        chk("t6_regrant", g, 2'b01);
        wait_idle("t6_idle");

        // Randomized traffic against the packet scoreboard.
        do_reset();
        sb_on = 1'b1;
        pk = 0;
        run = 0;
        d0 = done_cnt;
        a0 = abort_cnt;
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (pq[i].size() == 0 && ($urandom % 8) == 0) begin
                    push_pkt(i, 1 + int'($urandom % 5), 1'b1);
                    pk++;
                end
            end
            if (run >= 6) TXReady = 1'b1;
            else TXReady = (($urandom % 4) != 0);
            run = TXReady ? 0 : run + 1;
            rx_active = (($urandom % 6) == 0);
            drive();
            step();
        end
        TXReady = 1'b1;
        rx_active = 1'b0;
        drive();
        n = 0;
        while ((pq[0].size() != 0 || pq[1].size() != 0 || busy) && n < 5000) begin
            step();
            n++;
        end
        chk("rnd_drain", n < 5000, 1);
        chk("rnd_done_cnt", done_cnt - d0, pk);
        chk("rnd_no_abort", abort_cnt - a0, 0);
        chk("rnd_sb_empty", exq[0].size() + exq[1].size(), 0);
        sb_on = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
